// File: rtl/droop_detector_if.sv
// droop_detector_if: supply-monitor, droop_mgr status and brake/telemetry signals of droop_detector
//   enable        detector enable (level)
//   vmon_code     supply-monitor code, unsigned, lower = lower VDD
//   vmon_valid    vmon_code is valid this cycle
//   brake_state   droop_mgr state: 0 BRAKES_OFF, 1 BRAKING, 2 RECOVERING
//   clr_events    clear droop_events
//   brake         registered brake request
//   droop_events  saturating count of trips
//   det_state     detector state: 0 DISARMED, 1 ARMED, 2 TRIPPED, 3 HOLDOFF
interface droop_detector_if #(
    parameter int CODE_W = 10,
    parameter int CNT_W  = 8
);
    logic              enable;
    logic [CODE_W-1:0] vmon_code;
    logic              vmon_valid;
    logic [1:0]        brake_state;
    logic              clr_events;
    logic              brake;
    logic [CNT_W-1:0]  droop_events;
    logic [1:0]        det_state;

    modport master (
        output enable, vmon_code, vmon_valid, brake_state, clr_events,
        input  brake, droop_events, det_state
    );
    modport slave (
        input  enable, vmon_code, vmon_valid, brake_state, clr_events,
        output brake, droop_events, det_state
    );
endinterface

// File: rtl/droop_detector.sv
// droop_detector: debounced supply-droop detector driving the PLL brake request, with hysteresis and re-arm holdoff
//   refclk   clock, all logic on posedge
//   resetn   async active-low reset
//   bus      droop_detector_if.slave: enable, vmon_code/vmon_valid, brake_state, clr_events in;
//            brake, droop_events, det_state out
module droop_detector #(
    parameter int CODE_W         = 10,
    parameter int TRIP_CODE      = 400,
    parameter int RELEASE_CODE   = 450,
    parameter int DEBOUNCE       = 3,
    parameter int MIN_ASSERT     = 16,
    parameter int HOLDOFF_CYCLES = 64,
    parameter int CNT_W          = 8
) (
    input logic            refclk,
    input logic            resetn,
    droop_detector_if.slave bus
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int AW = $clog2(MIN_ASSERT + 1);
    localparam int HW = $clog2(HOLDOFF_CYCLES + 1);
    localparam logic [CODE_W-1:0] TRIP = CODE_W'(TRIP_CODE);
    localparam logic [CODE_W-1:0] REL  = CODE_W'(RELEASE_CODE);
    localparam logic [DW-1:0]     DEB  = DW'(DEBOUNCE);
    localparam logic [AW-1:0]     MINA = AW'(MIN_ASSERT);
    localparam logic [HW-1:0]     HOLD = HW'(HOLDOFF_CYCLES);
    localparam logic [1:0]        BRAKES_OFF = 2'd0;

    if (RELEASE_CODE <= TRIP_CODE) begin : g_bad_thresholds
        $error("droop_detector: RELEASE_CODE must be greater than TRIP_CODE");
    end
    if (DEBOUNCE < 1) begin : g_bad_debounce
        $error("droop_detector: DEBOUNCE must be at least 1");
    end

    typedef enum logic [1:0] {DISARMED, ARMED, TRIPPED, HOLDOFF} state_t;

    state_t           state, nxt;
    logic [DW-1:0]    low_cnt, high_cnt, low_nxt, high_nxt;
    logic [AW-1:0]    asrt_cnt;
    logic [HW-1:0]    hold_cnt;
    logic [CNT_W-1:0] events;
    logic             brake_q, is_low, is_high, low_done, high_done, rearm, entering, trip_in;

    always_comb begin
        is_low    = bus.vmon_valid && bus.vmon_code < TRIP;
        is_high   = bus.vmon_valid && bus.vmon_code >= REL;
        // invalid samples hold both runs; counters saturate at DEB
        low_nxt   = !bus.vmon_valid ? low_cnt : !is_low ? '0 : low_cnt == DEB ? low_cnt : low_cnt + 1'b1;
        high_nxt  = !bus.vmon_valid ? high_cnt : !is_high ? '0 : high_cnt == DEB ? high_cnt : high_cnt + 1'b1;
        low_done  = low_nxt == DEB;
        high_done = high_nxt == DEB;
        // hold_cnt == 1 here means this is the last required BRAKES_OFF edge
        rearm     = bus.brake_state == BRAKES_OFF && hold_cnt <= HW'(1);
        // trip is checked before re-arm so a simultaneous low wins in HOLDOFF
        nxt = !bus.enable ? DISARMED :
              state == DISARMED ? ARMED :
              (state == ARMED || state == HOLDOFF) && low_done ? TRIPPED :
              state == TRIPPED && high_done && asrt_cnt >= MINA ? HOLDOFF :
              state == HOLDOFF && rearm ? ARMED : state;
        entering = nxt != state;
        trip_in  = entering && nxt == TRIPPED;
    end

    always_ff @(posedge refclk or negedge resetn) begin
        if (!resetn) begin
            state    <= DISARMED;
            brake_q  <= 1'b0;
            low_cnt  <= '0;
            high_cnt <= '0;
            asrt_cnt <= '0;
            hold_cnt <= '0;
            events   <= '0;
        end else begin
            state    <= nxt;
            brake_q  <= nxt == TRIPPED;
            low_cnt  <= entering || !(nxt == ARMED || nxt == HOLDOFF) ? '0 : low_nxt;
            high_cnt <= entering || nxt != TRIPPED ? '0 : high_nxt;
            // entry edge counts as the first TRIPPED cycle
            asrt_cnt <= nxt != TRIPPED ? '0 : entering ? AW'(1) : asrt_cnt == MINA ? asrt_cnt : asrt_cnt + 1'b1;
            hold_cnt <= nxt != HOLDOFF || entering || bus.brake_state != BRAKES_OFF ? HOLD : hold_cnt - 1'b1;
            // clear first, then count the entry on the same edge
            events   <= bus.clr_events ? CNT_W'(trip_in) : events + CNT_W'(trip_in && events != '1);
        end
    end

    assign bus.brake        = brake_q;
    assign bus.droop_events = events;
    assign bus.det_state    = state;
endmodule

// File: tb/tb_droop_detector.sv
// tb_droop_detector: directed and randomized check of droop_detector (CNT_W=8 and CNT_W=2) against a run-length reference model
//   drives both DUTs from one stimulus stream; prints FAIL lines and a passed/total summary
module tb_droop_detector;
    localparam int TRIP = 400, REL = 450, DEB = 3, MINA = 16, HOLD = 64;

    logic refclk = 1'b0;
    logic resetn = 1'b0;

    droop_detector_if #(.CODE_W(10), .CNT_W(8)) i1 ();
    droop_detector_if #(.CODE_W(10), .CNT_W(2)) i2 ();

    droop_detector dut (.refclk(refclk), .resetn(resetn), .bus(i1));
    droop_detector #(.CNT_W(2)) dut2 (.refclk(refclk), .resetn(resetn), .bus(i2));

    assign i2.enable      = i1.enable;
    assign i2.vmon_code   = i1.vmon_code;
    assign i2.vmon_valid  = i1.vmon_valid;
    assign i2.brake_state = i1.brake_state;
    assign i2.clr_events  = i1.clr_events;

    always #5 refclk = ~refclk;

    int n_chk = 0, n_pass = 0;
    // reference model: consecutive-run lengths as plain integers
    int m_st, m_low, m_high, m_off, m_age, m_ev8, m_ev2;
    bit m_brake;

    task automatic check(input string tag, input int got, input int exp);
        n_chk++;
        if (got == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    endtask

    task automatic model_reset();
        m_st = 0; m_low = 0; m_high = 0; m_off = 0; m_age = 0; m_ev8 = 0; m_ev2 = 0; m_brake = 0;
    endtask

    task automatic model_step();
        bit lo, hi, tin;
        int ns;
        lo = i1.vmon_valid && i1.vmon_code < TRIP;
        hi = i1.vmon_valid && i1.vmon_code >= REL;
        if (i1.vmon_valid) begin
            m_low  = lo ? m_low + 1 : 0;
            m_high = hi ? m_high + 1 : 0;
        end
        m_off = i1.brake_state == 2'd0 ? m_off + 1 : 0;
        ns = m_st;
        if (!i1.enable) ns = 0;
        else if (m_st == 0) ns = 1;
        else if (m_st != 2 && m_low >= DEB) ns = 2;
        else if (m_st == 2 && m_high >= DEB && m_age >= MINA) ns = 3;
        else if (m_st == 3 && m_off >= HOLD) ns = 1;
        tin = ns == 2 && m_st != 2;
        m_ev8 = i1.clr_events ? int'(tin) : m_ev8 + int'(tin && m_ev8 < 255);
        m_ev2 = i1.clr_events ? int'(tin) : m_ev2 + int'(tin && m_ev2 < 3);
        m_age = ns != m_st ? 1 : m_age + 1;
        if (ns != m_st) begin
            m_low = 0; m_high = 0; m_off = 0;
        end
        m_st = ns;
        m_brake = ns == 2;
    endtask

    task automatic compare_all();
        check("state", int'(i1.det_state), m_st);
        check("brake", int'(i1.brake), int'(m_brake));
        check("events", int'(i1.droop_events), m_ev8);
        check("state_w2", int'(i2.det_state), m_st);
        check("events_w2", int'(i2.droop_events), m_ev2);
    endtask

    task automatic step(input bit en, input int code, input bit v, input int bs, input bit clr);
        i1.enable      = en;
        i1.vmon_code   = 10'(code);
        i1.vmon_valid  = v;
        i1.brake_state = 2'(bs);
        i1.clr_events  = clr;
        @(posedge refclk);
        if (resetn) model_step();
        @(negedge refclk);
        compare_all();
    endtask

    task automatic trip();
        for (int k = 0; k < 3; k++) step(1, 300, 1, 0, 0);
    endtask

    task automatic release_brake();
        for (int k = 0; k < 40 && i1.det_state != 2'd3; k++) step(1, 500, 1, 0, 0);
    endtask

    task automatic rearm();
        for (int k = 0; k < 100 && i1.det_state != 2'd1; k++) step(1, 500, 1, 0, 0);
    endtask

    initial begin
        int cnt, ev0, lvl, bs, code;
        model_reset();
        i1.enable = 0; i1.vmon_code = '0; i1.vmon_valid = 0; i1.brake_state = 0; i1.clr_events = 0;
        repeat (2) @(negedge refclk);
        check("rst_state", int'(i1.det_state), 0);
        check("rst_brake", int'(i1.brake), 0);
        check("rst_events", int'(i1.droop_events), 0);
        resetn = 1'b1;

        step(1, 500, 1, 0, 0);
        check("t1_armed", int'(i1.det_state), 1);
        repeat (5) step(1, 500, 1, 0, 0);
        check("t1_brake", int'(i1.brake), 0);

        step(1, 399, 1, 0, 0); step(1, 399, 1, 0, 0); step(1, 500, 1, 0, 0);
        step(1, 399, 1, 0, 0); step(1, 399, 1, 0, 0);
        check("t2_no_trip", int'(i1.brake), 0);
        step(1, 399, 1, 0, 0);
        check("t2_trip", int'(i1.brake), 1);
        check("t2_events", int'(i1.droop_events), 1);

        cnt = 1;
        for (int k = 0; k < 100; k++) begin
            step(1, 460, 1, 0, 0);
            if (!i1.brake) break;
            cnt++;
        end
        check("t3_min_assert", cnt, 16);
        check("t3_holdoff", int'(i1.det_state), 3);
        rearm();

        trip();
        repeat (40) step(1, 449, 1, 0, 0);
        check("t3_449_held", int'(i1.det_state), 2);
        step(1, 450, 1, 0, 0); step(1, 450, 1, 0, 0);
        check("t3_450_pending", int'(i1.det_state), 2);
        step(1, 450, 1, 0, 0);
        check("t3_450_release", int'(i1.det_state), 3);

        repeat (100) step(1, 500, 1, 2, 0);
        check("t4_recovering", int'(i1.det_state), 3);
        cnt = 0;
        for (int k = 0; k < 200 && i1.det_state != 2'd1; k++) begin
            step(1, 500, 1, 0, 0);
            cnt++;
        end
        check("t4_holdoff_len", cnt, 64);

        ev0 = m_ev8;
        trip();
        release_brake();
        for (int k = 0; k < 3; k++) step(1, 300, 1, 0, 0);
        check("t4_retrip", int'(i1.brake), 1);
        check("t4_events", int'(i1.droop_events), ev0 + 2);

        release_brake();
        rearm();
        step(1, 300, 1, 0, 0);
        repeat (5) step(1, 500, 0, 0, 0);
        step(1, 300, 1, 0, 0);
        check("t5_gap_hold", int'(i1.brake), 0);
        step(1, 300, 1, 0, 0);
        check("t5_gap_trip", int'(i1.brake), 1);
        step(0, 300, 1, 0, 0);
        check("t5_dis_brake", int'(i1.brake), 0);
        check("t5_dis_state", int'(i1.det_state), 0);
        step(1, 500, 1, 0, 0);
        trip();
        #2 resetn = 1'b0;
        model_reset();
        #1;
        check("t5_async_brake", int'(i1.brake), 0);
        check("t5_async_state", int'(i1.det_state), 0);
        @(negedge refclk);
        resetn = 1'b1;

        step(1, 500, 1, 0, 0);
        for (int t = 0; t < 5; t++) begin
            trip();
            release_brake();
            rearm();
        end
        check("t6_events_w8", int'(i1.droop_events), 5);
        check("t6_events_sat", int'(i2.droop_events), 3);
        step(1, 300, 1, 0, 0); step(1, 300, 1, 0, 0); step(1, 300, 1, 0, 1);
        check("t6_clr_trip_w8", int'(i1.droop_events), 1);
        check("t6_clr_trip_w2", int'(i2.droop_events), 1);

        lvl = 0; bs = 0;
        for (int k = 0; k < 4000; k++) begin
            if ($urandom_range(0, 9) == 0) lvl = $urandom_range(0, 3);
            if ($urandom_range(0, 29) == 0) bs = $urandom_range(0, 2);
            case (lvl)
                0: code = $urandom_range(250, 399);
                1: code = $urandom_range(400, 449);
                2: code = $urandom_range(450, 600);
                default: code = $urandom_range(0, 1023);
            endcase
            step($urandom_range(0, 199) != 0, code, $urandom_range(0, 6) != 0, bs, $urandom_range(0, 49) == 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
